// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the sequencer, stall/flush controls back out.
// Combinational only; no handshake and no backpressure of its own.
interface pipe_hazard_ctrl_if;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used_id;
    logic       rs2_used_id;
    logic [4:0] rd_ex;
    logic       mem_read_ex;
    logic       redirect_ex;
    logic       mdu_start_ex;
    logic       imem_ready;
    logic       dmem_req_mem;
    logic       dmem_ready;
    logic       stall_if;
    logic       stall_id;
    logic       flush_id;
    logic       stall_ex;
    logic       flush_ex;
    logic       flush_mem;
    logic       mdu_busy;
    logic       mdu_done;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               redirect_ex, mdu_start_ex, imem_ready, dmem_req_mem, dmem_ready,
        input  stall_if, stall_id, flush_id, stall_ex, flush_ex, flush_mem,
               mdu_busy, mdu_done
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               redirect_ex, mdu_start_ex, imem_ready, dmem_req_mem, dmem_ready,
        output stall_if, stall_id, flush_id, stall_ex, flush_ex, flush_mem,
               mdu_busy, mdu_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs are combinational from state and inputs.
// An MDU op occupies EX for MDU_LATENCY cycles; a data-memory wait freezes the whole sequencer.
module pipe_hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input logic           clk,
    input logic           rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {S_RUN, S_MDU} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             drop_fetch;

    logic freeze, mdu_stall, mdu_last, load_use, take_redirect, drop_now;
    logic stall_if_c, stall_id_c, flush_id_c, stall_ex_c, flush_ex_c, flush_mem_c, mdu_done_c;

    always_comb begin
        freeze        = hz.dmem_req_mem & ~hz.dmem_ready;
        mdu_stall     = ((state == S_RUN) & hz.mdu_start_ex) | ((state == S_MDU) & (cnt != '0));
        mdu_last      = (state == S_MDU) & (cnt == '0);
        load_use      = hz.mem_read_ex & (hz.rd_ex != 5'd0) &
                        ((hz.rs1_used_id & (hz.rs1_id == hz.rd_ex)) |
                         (hz.rs2_used_id & (hz.rs2_id == hz.rd_ex)));
        take_redirect = ~freeze & ~mdu_stall & ~mdu_last & hz.redirect_ex;

        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        flush_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        flush_ex_c  = 1'b0;
        flush_mem_c = 1'b0;
        mdu_done_c  = 1'b0;

        if (freeze) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            stall_ex_c = 1'b1;
        end else if (mdu_stall) begin
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            stall_ex_c  = 1'b1;
            flush_mem_c = 1'b1;
        end else if (mdu_last) begin
            mdu_done_c = 1'b1;
        end else if (hz.redirect_ex) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end else if (load_use) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end else if (!hz.imem_ready) begin
            stall_if_c = 1'b1;
            flush_id_c = 1'b1;
        end

        // The wrong-path fetch is only discarded in a cycle where IF/ID is free to load;
        // while ID is held the fetch is replayed and dropped later.
        drop_now = drop_fetch & hz.imem_ready & ~freeze & ~stall_id_c;
        if (drop_now) begin
            flush_id_c = 1'b1;
            stall_if_c = 1'b0;
        end
    end

    assign hz.stall_if  = stall_if_c;
    assign hz.stall_id  = stall_id_c;
    assign hz.flush_id  = flush_id_c;
    assign hz.stall_ex  = stall_ex_c;
    assign hz.flush_ex  = flush_ex_c;
    assign hz.flush_mem = flush_mem_c;
    assign hz.mdu_done  = mdu_done_c;
    assign hz.mdu_busy  = (state == S_MDU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            cnt        <= '0;
            drop_fetch <= 1'b0;
        end else if (!freeze) begin
            case (state)
                S_RUN: begin
                    if (hz.mdu_start_ex) begin
                        state <= S_MDU;
                        cnt   <= CNT_INIT;
                    end
                end
                S_MDU: begin
                    if (cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_RUN;
            endcase

            if (take_redirect & ~hz.imem_ready) begin
                drop_fetch <= 1'b1;
            end else if (drop_now) begin
                drop_fetch <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences for freeze/reset, then random vs model.
module tb_pipe_hazard_ctrl;
    localparam int MDU_LAT = 4;

    // Output vector bit order: stall_if stall_id flush_id stall_ex flush_ex flush_mem mdu_busy mdu_done
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       mdu;
        logic       iready;
        logic       dreq;
        logic       dready;
    } vin_t;

    typedef struct {
        vin_t       i;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   m_left;
    logic m_drop;
    vec_t tbl[$];

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MDU_LATENCY(MDU_LAT), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vin_t v(int rs1, int u1, int rs2, int u2, int rd, int mr,
                               int redir, int mdu, int ir, int dq, int dr);
        vin_t x;
        x.rs1 = 5'(rs1);   x.u1 = 1'(u1);
        x.rs2 = 5'(rs2);   x.u2 = 1'(u2);
        x.rd  = 5'(rd);    x.mr = 1'(mr);
        x.redir = 1'(redir); x.mdu = 1'(mdu);
        x.iready = 1'(ir); x.dreq = 1'(dq); x.dready = 1'(dr);
        return x;
    endfunction

    function automatic logic [7:0] dut_out();
        return {hz.stall_if, hz.stall_id, hz.flush_id, hz.stall_ex,
                hz.flush_ex, hz.flush_mem, hz.mdu_busy, hz.mdu_done};
    endfunction

    task automatic drive(input vin_t x);
        hz.rs1_id = x.rs1;       hz.rs1_used_id = x.u1;
        hz.rs2_id = x.rs2;       hz.rs2_used_id = x.u2;
        hz.rd_ex = x.rd;         hz.mem_read_ex = x.mr;
        hz.redirect_ex = x.redir; hz.mdu_start_ex = x.mdu;
        hz.imem_ready = x.iready; hz.dmem_req_mem = x.dreq;
        hz.dmem_ready = x.dready;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, compare mid-cycle, then advance past the edge.
    task automatic step(input string name, input vin_t x, input logic [7:0] exp);
        drive(x);
        @(negedge clk);
        check(name, dut_out(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", dut_out(), 8'b0000_0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_left = 0;
        m_drop = 1'b0;
    endtask

    // Reference: m_left counts remaining EX cycles of the current MDU op (0 = none).
    function automatic logic [7:0] model_out(input vin_t x);
        logic fr, lu, sif, sid, fid, sex, fex, fmem, busy, done;
        fr   = x.dreq && !x.dready;
        lu   = x.mr && (x.rd != 0) && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
        busy = (m_left > 0);
        {sif, sid, fid, sex, fex, fmem, done} = 7'b0;
        if (fr) begin
            {sif, sid, sex} = 3'b111;
        end else if (m_left > 1 || (m_left == 0 && x.mdu)) begin
            {sif, sid, sex, fmem} = 4'b1111;
        end else if (m_left == 1) begin
            done = 1'b1;
        end else if (x.redir) begin
            {fid, fex} = 2'b11;
        end else if (lu) begin
            {sif, sid, fex} = 3'b111;
        end else if (!x.iready) begin
            {sif, fid} = 2'b11;
        end
        if (m_drop && x.iready && !fr && !sid) begin
            fid = 1'b1;
            sif = 1'b0;
        end
        return {sif, sid, fid, sex, fex, fmem, busy, done};
    endfunction

    task automatic model_update(input vin_t x, input logic [7:0] o);
        logic fr, idle_ex, consume;
        fr      = x.dreq && !x.dready;
        idle_ex = (m_left == 0) && !x.mdu;
        consume = m_drop && x.iready && !fr && !o[6];
        if (!fr) begin
            if (m_left > 0) m_left = m_left - 1;
            else if (x.mdu) m_left = MDU_LAT - 1;
            if (idle_ex && x.redir && !x.iready) m_drop = 1'b1;
            else if (consume) m_drop = 1'b0;
        end
    endtask

    initial begin
        vin_t       idle;
        vin_t       x;
        logic [7:0] exp;
        checks = 0;
        errors = 0;
        idle   = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        tbl.push_back('{idle,                                   8'b0000_0000, "idle"});
        tbl.push_back('{v(3, 1, 5, 1, 5, 1, 0, 0, 1, 0, 0),     8'b1100_1000, "t1_loaduse_rs2"});
        tbl.push_back('{v(3, 1, 5, 1, 5, 0, 0, 0, 1, 0, 0),     8'b0000_0000, "t1_after_bubble"});
        tbl.push_back('{v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0),     8'b0000_0000, "t2_rd_zero"});
        tbl.push_back('{v(7, 0, 7, 0, 7, 1, 0, 0, 1, 0, 0),     8'b0000_0000, "loaduse_unused_srcs"});
        tbl.push_back('{v(7, 1, 2, 0, 7, 1, 0, 0, 1, 0, 0),     8'b1100_1000, "loaduse_rs1"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),     8'b1101_0100, "t3_mdu_c0"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),     8'b1101_0110, "t3_mdu_c1"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),     8'b1101_0110, "t3_mdu_c2"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),     8'b0000_0011, "t3_mdu_c3_done"});
        tbl.push_back('{idle,                                   8'b0000_0000, "t3_after"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),     8'b0010_1000, "t5_redirect_miss"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),     8'b1010_0000, "t5_imiss1"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),     8'b1010_0000, "t5_imiss2"});
        tbl.push_back('{idle,                                   8'b0010_0000, "t5_drop_fetch"});
        tbl.push_back('{idle,                                   8'b0000_0000, "t5_drop_cleared"});
        tbl.push_back('{v(9, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0),     8'b1100_1000, "loaduse_over_imiss"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0),     8'b0010_1000, "redirect_hit"});
        tbl.push_back('{idle,                                   8'b0000_0000, "redirect_hit_nodrop"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0),     8'b1101_0000, "freeze_over_redirect"});
        tbl.push_back('{v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1),     8'b0000_0000, "dmem_ready_no_freeze"});
        tbl.push_back('{v(4, 1, 0, 0, 4, 1, 1, 0, 1, 0, 0),     8'b0010_1000, "redirect_over_loaduse"});

        do_reset();
        foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].exp);

        // Freeze two cycles while cnt==1: op finishes two cycles late, flush_mem drops while frozen.
        x = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step("t4_start", x, 8'b1101_0100);
        step("t4_cnt2", x, 8'b1101_0110);
        x.dreq = 1'b1;
        step("t4_freeze1", x, 8'b1101_0010);
        step("t4_freeze2", x, 8'b1101_0010);
        x.dreq = 1'b0;
        step("t4_cnt1", x, 8'b1101_0110);
        step("t4_done", x, 8'b0000_0011);
        step("t4_after", idle, 8'b0000_0000);

        // Reset in the middle of an op, with a pending wrong-path drop.
        step("t6_redirect", v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 8'b0010_1000);
        x = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("t6_start", x, 8'b1101_0100);
        drive(x);
        @(negedge clk);
        check("t6_busy_cnt2", dut_out(), 8'b1101_0110);
        #1 rst_n = 1'b0;
        #1 check("t6_busy_in_reset", {7'b0, hz.mdu_busy}, 8'b0000_0000);
        drive(idle);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("t6_no_stale_drop", idle, 8'b0000_0000);
        step("t6_runs", v(1, 1, 0, 0, 2, 1, 0, 0, 1, 0, 0), 8'b0000_0000);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            x.rs1    = 5'($urandom_range(0, 3));
            x.rs2    = 5'($urandom_range(0, 3));
            x.rd     = 5'($urandom_range(0, 3));
            x.u1     = 1'($urandom_range(0, 1));
            x.u2     = 1'($urandom_range(0, 1));
            x.mr     = 1'($urandom_range(0, 1));
            x.redir  = ($urandom_range(0, 99) < 15);
            x.mdu    = ($urandom_range(0, 99) < 15);
            x.iready = ($urandom_range(0, 99) < 70);
            x.dreq   = ($urandom_range(0, 99) < 30);
            x.dready = 1'($urandom_range(0, 1));
            drive(x);
            exp = model_out(x);
            @(negedge clk);
            check("random", dut_out(), exp);
            checks++;
            if ((hz.stall_id & hz.flush_id) || (hz.stall_ex & hz.flush_ex)) begin
                errors++;
                $display("FAIL invariant: stall_id=%b flush_id=%b stall_ex=%b flush_ex=%b",
                         hz.stall_id, hz.flush_id, hz.stall_ex, hz.flush_ex);
            end
            model_update(x, exp);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
